dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
  - Port 0: the pipeline load/store unit (LSU).
  - Port 1: the DMA/debug loader.
- Sits between both requesters and the data memory's WE/RE/A/WD/RD interface.
- Fixed priority to port 0, with a starvation counter that forces a port-1 grant after a bounded wait.
- Read data is registered, so every read has 1-cycle response latency.

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the LSU (port 0)
// and the DMA/debug loader (port 1). Port 0 has fixed priority, but a
// starvation counter force-grants port 1 after STARVE_LIMIT refused cycles.
// Reads return registered data one cycle after the grant.
// Optional: define DMEM_ARB_STATS_EN to add grant/conflict statistics counters.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1,
  output logic [31:0]   conflict_cnt
`endif
);

  localparam int NP = 2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t                 last;
  logic                   last_rd;
  logic [3:0]             starve_cnt;
  logic                   force1;
  logic [NP-1:0]          gnt;
  logic [NP-1:0]          we;
  logic [NP-1:0][DW-1:0]  rdata_q;

  assign we = {we1, we0};

  // Arbitration: starvation override first, then fixed priority to port 0.
  // Reset suppresses every grant so nothing reaches memory while rst is high.
  always_comb begin
    force1 = req1 & (starve_cnt == LIMIT);
    gnt    = '0;
    if (!rst) begin
      if (force1)    gnt[1] = 1'b1;
      else if (req0) gnt[0] = 1'b1;
      else if (req1) gnt[1] = 1'b1;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Memory-side mux: granted port drives the interface, idle drives zeros.
  always_comb begin
    mem_we = 1'b0;
    mem_re = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (gnt[0]) begin
      mem_we = we0;
      mem_re = ~we0;
      mem_a  = addr0;
      mem_wd = wdata0;
    end else if (gnt[1]) begin
      mem_we = we1;
      mem_re = ~we1;
      mem_a  = addr1;
      mem_wd = wdata1;
    end
  end

  // Starvation counter: counts consecutive refused port-1 cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   starve_cnt <= '0;
    else if (!req1 || gnt[1])  starve_cnt <= '0;
    else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end

  // Last-grant FSM: remembers who was served and whether it was a read,
  // so the response valid can be steered to the right port next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= IDLE;
      last_rd <= 1'b0;
    end else begin
      case (1'b1)
        gnt[0]: begin
          last    <= SERVE0;
          last_rd <= ~we0;
        end
        gnt[1]: begin
          last    <= SERVE1;
          last_rd <= ~we1;
        end
        default: begin
          last    <= IDLE;
          last_rd <= 1'b0;
        end
      endcase
    end
  end

  assign rvalid0 = last_rd & (last == SERVE0);
  assign rvalid1 = last_rd & (last == SERVE1);

  // Per-port read data capture; holds the previous word between reads.
  for (genvar p = 0; p < NP; p++) begin : g_rsp
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  rdata_q[p] <= '0;
      else if (gnt[p] && !we[p]) rdata_q[p] <= mem_rd;
    end
  end

  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

`ifdef DMEM_ARB_STATS_EN
  // Statistics: grants per port and cycles where both ports competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt[0])        grant_cnt0   <= grant_cnt0 + 32'd1;
      if (gnt[1])        grant_cnt1   <= grant_cnt1 + 32'd1;
      if (req0 && req1)  conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a transaction-level model
// (reference memory array, wait counter, expected response per port).
module tb_dmem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   grant_cnt0, grant_cnt1, conflict_cnt;
  logic [31:0]   sg0, sg1, sc;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  // Memory device: 256 words, combinational read, write on rising edge.
  logic [31:0] dev_mem [0:255];
  logic        init_we = 1'b0;
  logic [7:0]  init_idx = '0;
  logic [31:0] init_d = '0;
  assign mem_rd = dev_mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (init_we)     dev_mem[init_idx] <= init_d;
    else if (mem_we) dev_mem[mem_a[9:2]] <= mem_wd;
  end

  // Model state
  int          nchk = 0;
  int          nerr = 0;
  int          waits;
  logic [31:0] ref_mem [0:255];
  logic        erv0, erv1, mg0, mg1;
  logic [31:0] erd0, erd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    waits = 0;
    erv0 = 1'b0; erv1 = 1'b0;
    erd0 = '0;   erd1 = '0;
    mg0 = 1'b0;  mg1 = 1'b0;
  endtask

  // Settle, compare every output with the model, then advance the model
  // to what the next cycle must show.
  task automatic eval();
    logic          ewe, ere;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    #1;
    mg0 = 1'b0; mg1 = 1'b0;
    if (!rst) begin
      if (req1 && waits >= LIM) mg1 = 1'b1;
      else if (req0)            mg0 = 1'b1;
      else if (req1)            mg1 = 1'b1;
    end
    ewe = mg0 ? we0 : (mg1 ? we1 : 1'b0);
    ere = mg0 ? !we0 : (mg1 ? !we1 : 1'b0);
    ea  = mg0 ? addr0 : (mg1 ? addr1 : '0);
    ewd = mg0 ? wdata0 : (mg1 ? wdata1 : '0);
    chk("gnt0", gnt0, mg0);
    chk("gnt1", gnt1, mg1);
    chk("mem_we", mem_we, ewe);
    chk("mem_re", mem_re, ere);
    chk("mem_a", mem_a, ea);
    chk("mem_wd", mem_wd, ewd);
    chk("rvalid0", rvalid0, erv0);
    chk("rvalid1", rvalid1, erv1);
    chk("rdata0", rdata0, erd0);
    chk("rdata1", rdata1, erd1);
    if (rst) begin
      reset_model();
    end else begin
      waits = (req1 && !mg1) ? ((waits < LIM) ? waits + 1 : LIM) : 0;
      erv0 = mg0 && !we0;
      erv1 = mg1 && !we1;
      if (erv0) erd0 = ref_mem[addr0[9:2]];
      if (erv1) erd1 = ref_mem[addr1[9:2]];
      if (mg0 && we0) ref_mem[addr0[9:2]] = wdata0;
      if (mg1 && we1) ref_mem[addr1[9:2]] = wdata1;
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  function automatic logic [31:0] raddr();
    return {22'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    int pct0, pct1;
    rst = 1'b1;
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    reset_model();

    // Load memory while in reset.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i == 64) v = 32'h1234_5678;
      if (i == 0)  v = 32'hA0A0_0000;
      if (i == 1)  v = 32'hB1B1_0004;
      init_we = 1'b1; init_idx = 8'(i); init_d = v;
      ref_mem[i] = v;
      @(negedge clk);
    end
    init_we = 1'b0;

    // Reset state: requests present but nothing granted.
    set0(1'b1, 1'b0, 32'h100, '0);
    set1(1'b1, 1'b0, 32'h4, '0);
    eval();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);
    @(negedge clk);
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    rst = 1'b0;

    // Single port-0 read.
    set0(1'b1, 1'b0, 32'h100, '0);
    eval();
    chk("t1_gnt0", gnt0, 1);
    @(negedge clk);
    set0(1'b0, 1'b0, '0, '0);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 32'h1234_5678);
    chk("t1_rvalid1", rvalid1, 0);
    eval(); @(negedge clk);

    // Port-1 write then readback.
    set1(1'b1, 1'b1, 32'h200, 32'hCAFE_F00D);
    eval();
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_a", mem_a, 32'h200);
    chk("t2_mem_wd", mem_wd, 32'hCAFE_F00D);
    @(negedge clk);
    set1(1'b1, 1'b0, 32'h200, '0);
    eval();
    chk("t2_gnt1", gnt1, 1);
    @(negedge clk);
    set1(1'b0, 1'b0, '0, '0);
    chk("t2_rvalid1", rvalid1, 1);
    chk("t2_rdata1", rdata1, 32'hCAFE_F00D);
    eval(); @(negedge clk);

    // Both held: 4:1 pattern.
`ifdef DMEM_ARB_STATS_EN
    sg0 = grant_cnt0; sg1 = grant_cnt1; sc = conflict_cnt;
`endif
    set0(1'b1, 1'b0, 32'h100, '0);
    set1(1'b1, 1'b0, 32'h200, '0);
    for (int k = 0; k < 10; k++) begin
      eval();
      chk("t3_gnt1", gnt1, (k == 4 || k == 9));
      chk("t3_gnt0", gnt0, !(k == 4 || k == 9));
      @(negedge clk);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("st_grant0", grant_cnt0 - sg0, 8);
    chk("st_grant1", grant_cnt1 - sg1, 2);
    chk("st_conflict", conflict_cnt - sc, 10);
`endif
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    eval(); @(negedge clk);

    // Alternating back-to-back reads.
    set0(1'b1, 1'b0, 32'h0, '0);
    set1(1'b1, 1'b0, 32'h4, '0);
    eval();
    chk("t4_gnt0", gnt0, 1);
    @(negedge clk);
    set0(1'b0, 1'b0, '0, '0);
    chk("t4_rvalid0", rvalid0, 1);
    chk("t4_rdata0", rdata0, 32'hA0A0_0000);
    eval();
    chk("t4_gnt1", gnt1, 1);
    @(negedge clk);
    set1(1'b0, 1'b0, '0, '0);
    chk("t4_rvalid1", rvalid1, 1);
    chk("t4_rdata1", rdata1, 32'hB1B1_0004);
    chk("t4_rvalid0_off", rvalid0, 0);
    eval(); @(negedge clk);

    // Async reset mid-cycle during a granted read with three refused port-1 cycles.
    set0(1'b1, 1'b0, 32'h100, '0);
    set1(1'b1, 1'b0, 32'h4, '0);
    for (int k = 0; k < 3; k++) begin
      eval(); @(negedge clk);
    end
    #1;
    chk("t5_gnt0_pre", gnt0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_gnt0", gnt0, 0);
    chk("t5_gnt1", gnt1, 0);
    chk("t5_mem_re", mem_re, 0);
    chk("t5_rvalid0", rvalid0, 0);
    chk("t5_rvalid1", rvalid1, 0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      eval();
      if (k == 0) chk("t5_rvalid0_post", rvalid0, 0);
      chk("t5_gnt1_post", gnt1, (k == 4));
      @(negedge clk);
    end
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    eval(); @(negedge clk);

    // Randomized traffic with the hold-until-granted protocol.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       begin pct0 = 90; pct1 = 60; end
        1:       begin pct0 = 50; pct1 = 50; end
        default: begin pct0 = 20; pct1 = 90; end
      endcase
      if (!req0 || mg0)
        set0(($urandom % 100) < pct0, 1'($urandom), raddr(), $urandom);
      if (!req1 || mg1)
        set1(($urandom % 100) < pct1, 1'($urandom), raddr(), $urandom);
      eval();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
